// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer for a 4-bit-address program ROM.
// It fetches the byte at pc, offers it to the decoder, and advances pc on
// the handshake. Taken jumps (JMP and JNC) are resolved on that same edge.
// A fetch that gets no ack for 8 cycles is abandoned through a one-cycle
// RETRY state, and then the same address is fetched again.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   halt               stop fetching; checked in IDLE and at issue handshake
//   carry              ALU carry, used by JNC at the handshake edge only
//   rom_req/rom_addr   program-memory read request and address (= pc)
//   rom_ack/rom_data   read data valid (honoured only in FETCH) and byte
//   inst/inst_valid    instruction to decoder ([7:4] opcode, [3:0] imm)
//   inst_ready         decoder accepts inst
//   pc                 current program counter
//   fetch_err          one-cycle pulse when a fetch times out
module fetch_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  input  logic       carry,
  output logic       rom_req,
  output logic [3:0] rom_addr,
  input  logic       rom_ack,
  input  logic [7:0] rom_data,
  output logic [7:0] inst,
  output logic       inst_valid,
  input  logic       inst_ready,
  output logic [3:0] pc,
  output logic       fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, RETRY} state_t;

  localparam logic [3:0] OP_JMP = 4'b1111;
  localparam logic [3:0] OP_JNC = 4'b1110;

  state_t     r_state, w_next;
  logic [3:0] r_pc, w_pc_next;
  logic [7:0] r_inst;
  logic [2:0] r_cnt;
  logic       w_hs, w_ack;

  assign w_ack = (r_state == FETCH) && rom_ack;
  assign w_hs  = (r_state == ISSUE) && inst_ready;

  // Branch resolution. Only the handshake edge uses this, so carry has no
  // effect at any other time.
  always_comb begin
    w_pc_next = r_pc + 4'd1;
    if (r_inst[7:4] == OP_JMP)
      w_pc_next = r_inst[3:0];
    else if (r_inst[7:4] == OP_JNC && !carry)
      w_pc_next = r_inst[3:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (!halt) w_next = FETCH;
      // An ack always wins, including on the last cycle before timeout.
      FETCH: if (rom_ack)           w_next = ISSUE;
             else if (r_cnt == 3'd7) w_next = RETRY;
      ISSUE: if (inst_ready) w_next = halt ? IDLE : FETCH;
      RETRY: w_next = FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= 4'd0;
      r_inst  <= 8'h00;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_ack) r_inst <= rom_data;
      // The count is held at 0 outside FETCH, so every entry to FETCH
      // starts from zero. It wraps to 0 when the fetch moves to RETRY.
      if (r_state == FETCH && !rom_ack) r_cnt <= r_cnt + 3'd1;
      else                              r_cnt <= 3'd0;
      if (w_hs) r_pc <= w_pc_next;
    end
  end

  // All outputs come from the state register or from other registers.
  assign rom_req    = (r_state == FETCH);
  assign inst_valid = (r_state == ISSUE);
  assign fetch_err  = (r_state == RETRY);
  assign rom_addr   = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;

endmodule
